ds_dac_sl: RTL and testbench
============================

DS_DAC_SL -- requirements
Module: ds_dac_sl

Interface
REQ-001 Parameter DIN_W, default 16: width of the unsigned input sample; all listed values assume 16.
REQ-002 Single clock; reset is synchronous and active-high.
REQ-003 clk50m  input  1  rising-edge system clock, 50 MHz nominal.
REQ-004 rst_n  input  1  synchronous, active-high reset; the name is kept per codebase, and a value of 1 resets.
REQ-005 clk_enable  input  1  clock enable; the modulator advances only on cycles where it is 1.
REQ-006 din  input  DIN_W  unsigned sample; full scale 0..2^DIN_W-1; may change on any cycle.
REQ-007 ce_out  output  1  clk_enable delayed by one clock; qualifies the dout sample.
REQ-008 dout  output  1  registered 1-bit delta-sigma bitstream.

Function
REQ-009 Core (first order, default): DIN_W-bit unsigned accumulator acc; on each enabled cycle, sum = acc + din (DIN_W+1 bits), acc <= sum[DIN_W-1:0], dout <= sum[DIN_W].
REQ-010 Density: over any 2^DIN_W consecutive enabled cycles starting from acc=0, the count of dout=1 equals din exactly for constant din.
REQ-011 Latency: dout on the clock after an enabled edge reflects din sampled at that edge; one cycle in total.
REQ-012 Disabled cycles (clk_enable=0): acc, integrators and dout hold their values; din is ignored.
REQ-013 ce_out <= clk_enable on every clock edge, independent of enable.
REQ-014 Wrap-around: accumulator overflow is the intended carry-out; no saturation in first order.
REQ-015 din=0: dout stays 0 forever; din=2^DIN_W-1: dout is 0 exactly once per 2^DIN_W enabled cycles.
REQ-016 All state is updated only on the rising clk50m edge; there are no combinational paths from din to dout.

Reset
REQ-017 While rst_n=1 at a rising edge: acc=0, integrators=0, dout=0, ce_out=0; reset overrides clk_enable.
REQ-018 Reset mid-operation discards accumulated error; the first enabled cycle after release behaves as from power-up.

Configuration
REQ-019 Macro DS_DAC_SL_SECOND_ORDER_EN; when undefined, the first-order core of REQ-009 is built.
REQ-020 When defined: signed offset input x = din - 2^(DIN_W-1); feedback fb = +2^(DIN_W-1) if dout=1, else -2^(DIN_W-1).
REQ-021 Second-order update per enabled cycle: i1n = i1 + x - fb; i2n = i2 + i1n - fb; i1 <= i1n; i2 <= i2n; dout <= (i2n >= 0).
REQ-022 i1 and i2 are signed DIN_W+4 bits, saturating at their min/max and never wrapping.
REQ-023 In second-order mode, REQ-010 holds as a long-run average within ±4 ones per 2^DIN_W cycles; REQ-011 to REQ-018 still apply.

Verification
REQ-024 Reset held 3 cycles, then released with clk_enable=1 and din=0 -> ce_out=1 from the second clock after release; dout=0 for 1000 cycles.
REQ-025 First order, din=32768 -> after the first enabled cycle dout alternates 0,1,0,1; din=16384 -> exactly one 1 in every 4 cycles.
REQ-026 First order, din=65535 for 65536 cycles -> exactly 65535 ones; din=1 -> exactly one 1.
REQ-027 din=40000 with clk_enable toggled pseudo-randomly -> dout/acc frozen on disabled cycles; the ones count over enabled cycles matches REQ-010.
REQ-028 Assert rst_n mid-stream with din=50000 -> dout=0 and ce_out=0 on the next edge; the bitstream after release is identical to the power-up sequence.
REQ-029 Sine din = 32767*sin(2*pi*1 kHz*t)+32767 for 1 ms, in both macro builds -> low-pass-filtered dout tracks din/65536 within 1 % of full scale; no integrator overflow.

Source files
------------

// File: rtl/ds_dac_sl.sv
// ds_dac_sl -- 1-bit delta-sigma DAC modulator.
//
// Converts an unsigned DIN_W-bit sample stream into a registered 1-bit
// bitstream whose density of ones tracks din / 2^DIN_W.
//
// Build options:
//   DS_DAC_SL_SECOND_ORDER_EN  undefined (default): first-order phase
//                              accumulator, dout is the carry-out.
//                              defined: second-order loop with two
//                              saturating signed integrators.
//
// Reset is synchronous and active-high on the port named rst_n (the name
// is inherited from the surrounding codebase). Reset wins over clk_enable.
// The modulator state only advances on cycles with clk_enable=1; ce_out is
// clk_enable delayed by one clock and qualifies each dout sample.

module ds_dac_sl #(
    parameter int DIN_W = 16
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic             clk_enable,
    input  logic [DIN_W-1:0] din,
    output logic             ce_out,
    output logic             dout
);

    logic r_ce_out;
    logic r_dout;

    assign ce_out = r_ce_out;
    assign dout   = r_dout;

    // Delay the clock enable by one clock so downstream logic knows which
    // dout samples are fresh; runs regardless of clk_enable.
    always_ff @(posedge clk50m) begin
        // NOTE: reset is sampled on the clock edge (synchronous), so it
        // belongs inside the edge-triggered block rather than its
        // sensitivity list; all state uses non-blocking assignments.
        if (rst_n) begin
            r_ce_out <= 1'b0;
        end else begin
            r_ce_out <= clk_enable;
        end
    end

`ifdef DS_DAC_SL_SECOND_ORDER_EN

    // Integrators are four bits wider than the sample to give headroom for
    // the loop swing; the extended width leaves two more guard bits so the
    // pre-saturation sums can never wrap.
    localparam int IW = DIN_W + 4;
    localparam int EW = DIN_W + 6;

    localparam logic signed [EW-1:0] HALF   = EW'(2 ** (DIN_W - 1));
    localparam logic signed [EW-1:0] SAT_HI = EW'(2 ** (IW - 1) - 1);
    localparam logic signed [EW-1:0] SAT_LO = -SAT_HI - EW'(1);

    logic signed [IW-1:0] r_i1;
    logic signed [IW-1:0] r_i2;

    logic signed [EW-1:0] w_x;
    logic signed [EW-1:0] w_fb;
    logic signed [EW-1:0] w_i1_ext;
    logic signed [EW-1:0] w_i2_ext;
    logic signed [IW-1:0] w_i1n;
    logic signed [IW-1:0] w_i2n;

    // Clamp an extended-width sum into the integrator range instead of
    // letting it wrap, which would flip the loop's sign and destabilise it.
    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[IW-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[IW-1:0];
        end else begin
            return v[IW-1:0];
        end
    endfunction

    // Offset the unsigned sample to a signed value centred on zero, and
    // pick the feedback level from the previous output bit.
    assign w_x  = $signed({{(EW - DIN_W){1'b0}}, din}) - HALF;
    assign w_fb = r_dout ? HALF : -HALF;

    // Two cascaded integrators; the second sees the already-updated first.
    assign w_i1_ext = {{(EW - IW){r_i1[IW-1]}}, r_i1} + w_x - w_fb;
    assign w_i1n    = sat(w_i1_ext);
    assign w_i2_ext = {{(EW - IW){r_i2[IW-1]}}, r_i2}
                    + {{(EW - IW){w_i1n[IW-1]}}, w_i1n} - w_fb;
    assign w_i2n    = sat(w_i2_ext);

    // Advance both integrators and quantise the second on enabled cycles.
    always_ff @(posedge clk50m) begin
        if (rst_n) begin
            r_i1   <= '0;
            r_i2   <= '0;
            r_dout <= 1'b0;
        end else if (clk_enable) begin
            r_i1   <= w_i1n;
            r_i2   <= w_i2n;
            r_dout <= ~w_i2n[IW-1];
        end
    end

`else

    logic [DIN_W-1:0] r_acc;
    logic [DIN_W:0]   w_sum;

    // The carry out of the accumulator is the output bit; overflow is the
    // modulation mechanism, so the sum is deliberately left to wrap.
    assign w_sum = {1'b0, r_acc} + {1'b0, din};

    // Advance the phase accumulator and register the carry on enabled cycles.
    always_ff @(posedge clk50m) begin
        if (rst_n) begin
            r_acc  <= '0;
            r_dout <= 1'b0;
        end else if (clk_enable) begin
            r_acc  <= w_sum[DIN_W-1:0];
            r_dout <= w_sum[DIN_W];
        end
    end

`endif

endmodule

// File: tb/tb_ds_dac_sl.sv
// tb_ds_dac_sl -- self-checking bench for ds_dac_sl (default first-order build).
//
// Reference model: the running total of every din accepted on an enabled
// cycle. The k-th output bit is 1 exactly when that total crosses a new
// multiple of 2^DIN_W, i.e. dout_k = floor(S_k/2^W) - floor(S_(k-1)/2^W).

module tb_ds_dac_sl;

    localparam int W = 16;

    logic         clk50m = 1'b0;
    logic         rst_n;
    logic         clk_enable;
    logic [W-1:0] din;
    logic         ce_out;
    logic         dout;

    int vectors     = 0;
    int miscompares = 0;

    longint unsigned m_sum;
    logic            m_dout;
    logic            m_ce;

    always #10 clk50m = ~clk50m;

    ds_dac_sl #(.DIN_W(W)) dut (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .din        (din),
        .ce_out     (ce_out),
        .dout       (dout)
    );

    // Drive one clock worth of inputs, advance the model at the edge, and
    // return 1 time unit after the edge so outputs are settled.
    task automatic tick(input logic r, input logic en, input logic [W-1:0] d);
        longint unsigned nxt;
        rst_n      = r;
        clk_enable = en;
        din        = d;
        @(posedge clk50m);
        if (r) begin
            m_sum  = 0;
            m_dout = 1'b0;
            m_ce   = 1'b0;
        end else begin
            m_ce = en;
            if (en) begin
                nxt    = m_sum + longint'(d);
                m_dout = ((nxt >> W) != (m_sum >> W));
                m_sum  = nxt;
            end
        end
        #1;
    endtask

    // Reset held three cycles, then din=0 with enable high for 1000 cycles.
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, W'($urandom));
            vectors++;
            if (dout !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_dout cyc=%0d got=%b exp=0", i, dout);
            end
            vectors++;
            if (ce_out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ce cyc=%0d got=%b exp=0", i, ce_out);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0, 1'b1, '0);
            vectors++;
            if (ce_out !== 1'b1) begin
                miscompares++;
                $display("FAIL zero_ce cyc=%0d got=%b exp=1", i, ce_out);
            end
            vectors++;
            if (dout !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_dout cyc=%0d got=%b exp=0", i, dout);
            end
        end
    endtask

    // Mid-scale alternates 0,1,0,1; quarter-scale gives one 1 in every four.
    task automatic test_patterns();
        int ones;
        tick(1'b1, 1'b0, '0);
        for (int k = 1; k <= 16; k++) begin
            tick(1'b0, 1'b1, 16'd32768);
            vectors++;
            if (dout !== logic'(k % 2 == 0)) begin
                miscompares++;
                $display("FAIL half k=%0d got=%b exp=%b", k, dout, k % 2 == 0);
            end
        end
        tick(1'b1, 1'b0, '0);
        ones = 0;
        for (int k = 1; k <= 64; k++) begin
            tick(1'b0, 1'b1, 16'd16384);
            ones += int'(dout);
            vectors++;
            if (dout !== m_dout) begin
                miscompares++;
                $display("FAIL quarter k=%0d got=%b exp=%b", k, dout, m_dout);
            end
            if (k % 4 == 0) begin
                vectors++;
                if (ones != 1) begin
                    miscompares++;
                    $display("FAIL quarter_window k=%0d got=%0d exp=1", k, ones);
                end
                ones = 0;
            end
        end
    endtask

    // Full-scale produces a 0 only on the first enabled cycle of the span;
    // din=1 produces no 1 within a span shorter than 2^W.
    task automatic test_extremes();
        int ones;
        int n;
        n = 16384;
        tick(1'b1, 1'b0, '0);
        ones = 0;
        for (int k = 1; k <= n; k++) begin
            tick(1'b0, 1'b1, 16'hFFFF);
            ones += int'(dout);
            if (dout !== m_dout) begin
                vectors++;
                miscompares++;
                $display("FAIL fullscale k=%0d got=%b exp=%b", k, dout, m_dout);
            end
        end
        vectors++;
        if (ones != n - 1) begin
            miscompares++;
            $display("FAIL fullscale_count got=%0d exp=%0d", ones, n - 1);
        end
        tick(1'b1, 1'b0, '0);
        ones = 0;
        for (int k = 1; k <= n; k++) begin
            tick(1'b0, 1'b1, 16'd1);
            ones += int'(dout);
        end
        vectors++;
        if (ones != 0) begin
            miscompares++;
            $display("FAIL din1_count got=%0d exp=0", ones);
        end
    endtask

    // din=40000 with a random enable: output frozen on disabled cycles and
    // the ones count equals floor(enabled*din/2^W).
    task automatic test_enable_toggle();
        int   ones;
        int   n_en;
        logic en;
        logic prev;
        tick(1'b1, 1'b0, '0);
        ones = 0;
        n_en = 0;
        for (int k = 0; k < 4000; k++) begin
            en   = logic'($urandom_range(1, 0));
            prev = dout;
            tick(1'b0, en, en ? 16'd40000 : W'($urandom));
            vectors++;
            if (ce_out !== en) begin
                miscompares++;
                $display("FAIL toggle_ce k=%0d got=%b exp=%b", k, ce_out, en);
            end
            if (en) begin
                n_en++;
                ones += int'(dout);
                vectors++;
                if (dout !== m_dout) begin
                    miscompares++;
                    $display("FAIL toggle_dout k=%0d got=%b exp=%b", k, dout, m_dout);
                end
            end else begin
                vectors++;
                if (dout !== prev) begin
                    miscompares++;
                    $display("FAIL toggle_hold k=%0d got=%b exp=%b", k, dout, prev);
                end
            end
        end
        vectors++;
        if (longint'(ones) != (longint'(n_en) * 40000) / 65536) begin
            miscompares++;
            $display("FAIL toggle_count got=%0d exp=%0d", ones,
                     (longint'(n_en) * 40000) / 65536);
        end
    endtask

    // Random samples, random enable and occasional resets against the model.
    task automatic test_random();
        logic r;
        logic en;
        tick(1'b1, 1'b0, '0);
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(199, 0) == 0);
            en = logic'($urandom_range(1, 0));
            tick(r, en, W'($urandom));
            vectors++;
            if (dout !== m_dout) begin
                miscompares++;
                $display("FAIL random_dout k=%0d got=%b exp=%b", k, dout, m_dout);
            end
            vectors++;
            if (ce_out !== m_ce) begin
                miscompares++;
                $display("FAIL random_ce k=%0d got=%b exp=%b", k, ce_out, m_ce);
            end
        end
    endtask

    // A reset in mid-stream clears the outputs at once, and the sequence
    // after release repeats the one seen after the first reset.
    task automatic test_midstream_reset();
        logic first_seq [40];
        tick(1'b1, 1'b0, '0);
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, 1'b1, 16'd50000);
            first_seq[k] = dout;
            vectors++;
            if (dout !== m_dout) begin
                miscompares++;
                $display("FAIL mid_first k=%0d got=%b exp=%b", k, dout, m_dout);
            end
        end
        for (int k = 0; k < 25; k++) begin
            tick(1'b0, 1'b1, 16'd50000);
        end
        tick(1'b1, 1'b1, 16'd50000);
        vectors++;
        if (dout !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_dout got=%b exp=0", dout);
        end
        vectors++;
        if (ce_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ce got=%b exp=0", ce_out);
        end
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, 1'b1, 16'd50000);
            vectors++;
            if (dout !== first_seq[k]) begin
                miscompares++;
                $display("FAIL mid_repeat k=%0d got=%b exp=%b", k, dout, first_seq[k]);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        clk_enable = 1'b0;
        din        = '0;
        m_sum      = 0;
        m_dout     = 1'b0;
        m_ce       = 1'b0;
        test_reset();
        test_patterns();
        test_extremes();
        test_enable_toggle();
        test_random();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
